// File: rtl/memory_stage_if.sv
// Memory-stage bundle: upstream execute-stage handoff, result return and data-memory port.
// The stage itself uses the slave view; the driver of stage inputs uses the master view.
interface memory_stage_if;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_rs2_data;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_fault;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    modport slave (
        input  i_valid, i_mem_read, i_mem_write, i_funct3, i_alu_result, i_rs2_data,
        input  i_dmem_ready, i_dmem_rvalid, i_dmem_rdata,
        output o_busy, o_valid, o_result, o_fault,
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_mask
    );

    modport master (
        output i_valid, i_mem_read, i_mem_write, i_funct3, i_alu_result, i_rs2_data,
        output i_dmem_ready, i_dmem_rvalid, i_dmem_rdata,
        input  o_busy, o_valid, o_result, o_fault,
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_mask
    );
endinterface

// File: rtl/memory_stage.sv
// Load/store stage: latches one execute-stage result, runs a single data-memory access,
// and returns the extended load data, the pass-through value, or a fault.
//
// state | meaning
// IDLE  | empty, sampling i_valid
// REQ   | dmem request held until i_dmem_ready
// WAIT  | load accepted, waiting for i_dmem_rvalid
// DONE  | o_valid pulse, i_valid ignored
module memory_stage (
    input  logic          i_clk,
    input  logic          i_rst_n,
    memory_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        op_read;
    logic        op_write;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] rs2_q;
    logic [31:0] result_q;
    logic        fault_q;

    logic        in_mem_op;
    logic        in_fault;
    logic [31:0] load_ext;
    logic [3:0]  mask_w;
    logic [31:0] wdata_w;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Fault decode runs on the live inputs so the decision is made in the IDLE cycle.
    always_comb begin
        in_mem_op = bus.i_mem_read | bus.i_mem_write;
        in_fault  = 1'b0;
        if (in_mem_op) begin
            if (bus.i_mem_read && bus.i_mem_write)
                in_fault = 1'b1;
            if (bus.i_funct3 == 3'b011 || bus.i_funct3 == 3'b110 || bus.i_funct3 == 3'b111)
                in_fault = 1'b1;
            if (bus.i_funct3[1:0] == 2'b01 && bus.i_alu_result[0])
                in_fault = 1'b1;
            if (bus.i_funct3[1:0] == 2'b10 && bus.i_alu_result[1:0] != 2'b00)
                in_fault = 1'b1;
        end
    end

    always_comb begin
        byte_sel = bus.i_dmem_rdata[8*addr_q[1:0] +: 8];
        half_sel = addr_q[1] ? bus.i_dmem_rdata[31:16] : bus.i_dmem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = bus.i_dmem_rdata;
        endcase
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                mask_w  = 4'b0001 << addr_q[1:0];
                wdata_w = {4{rs2_q[7:0]}};
            end
            2'b01: begin
                mask_w  = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_w = {2{rs2_q[15:0]}};
            end
            default: begin
                mask_w  = 4'b1111;
                wdata_w = rs2_q;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.i_valid) state_nxt = (in_fault || !in_mem_op) ? DONE : REQ;
            REQ:  if (bus.i_dmem_ready) state_nxt = op_write ? DONE : WAIT;
            WAIT: if (bus.i_dmem_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            op_read  <= 1'b0;
            op_write <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= 32'h0;
            rs2_q    <= 32'h0;
            result_q <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        op_read  <= bus.i_mem_read;
                        op_write <= bus.i_mem_write;
                        f3_q     <= bus.i_funct3;
                        addr_q   <= bus.i_alu_result;
                        rs2_q    <= bus.i_rs2_data;
                        if (in_fault) begin
                            fault_q <= 1'b1;
                        end else if (!in_mem_op) begin
                            fault_q  <= 1'b0;
                            result_q <= bus.i_alu_result;
                        end
                    end
                end
                REQ: begin
                    if (bus.i_dmem_ready && op_write)
                        fault_q <= 1'b0;
                end
                // Only WAIT captures read data, so an rvalid in the acceptance cycle is dropped.
                WAIT: begin
                    if (bus.i_dmem_rvalid) begin
                        result_q <= load_ext;
                        fault_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy       = (state != IDLE);
    assign bus.o_valid      = (state == DONE);
    assign bus.o_result     = result_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_dmem_req   = (state == REQ);
    assign bus.o_dmem_we    = (state == REQ) && op_write;
    assign bus.o_dmem_addr  = {addr_q[31:2], 2'b00};
    assign bus.o_dmem_wdata = wdata_w;
    assign bus.o_dmem_mask  = (state == REQ) ? mask_w : 4'b0000;

    logic unused_ok;
    assign unused_ok = op_read;
endmodule

// File: tb/tb_memory_stage.sv
// Randomized and directed bench for memory_stage against a byte-lane reference model.
module tb_memory_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_stage_if bus();
    memory_stage dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] addr);
        int off;
        off = int'(addr[1:0]);
        if (!(rd || wr)) return 1'b0;
        if (rd && wr) return 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (off % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int n, off;
        longint v;
        n = size_bytes(f3);
        off = int'(addr[1:0]);
        if (n == 4) off = 0;
        v = 0;
        for (int k = 0; k < n; k++)
            v += longint'((word >> (8 * (off + k))) & 32'hFF) << (8 * k);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] m;
        int n, off;
        m = 4'b0000;
        n = size_bytes(f3);
        off = (n == 4) ? 0 : int'(addr[1:0]);
        for (int k = 0; k < n; k++) m[off + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] w;
        int n;
        n = size_bytes(f3);
        for (int k = 0; k < 4; k++) w[8 * k +: 8] = rs2[8 * (k % n) +: 8];
        return w;
    endfunction

    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int d, input int r,
                           input bit spurious, input string name);
        bit exp_f, legal_mem, has_result;
        int exp_lat, cyc, req_cycles, accepted, accept_cyc, done_cyc;
        logic [31:0] exp_res;
        exp_f      = ref_fault(rd, wr, f3, addr);
        legal_mem  = (rd || wr) && !exp_f;
        has_result = !exp_f && (!(rd || wr) || rd);
        exp_lat    = !legal_mem ? 2 : (wr ? 3 + d : 4 + d + r - 1);
        exp_res    = (rd || wr) ? ref_load(f3, addr, rdata) : addr;

        bus.i_valid      = 1'b1;
        bus.i_mem_read   = rd;
        bus.i_mem_write  = wr;
        bus.i_funct3     = f3;
        bus.i_alu_result = addr;
        bus.i_rs2_data   = rs2;
        bus.i_dmem_ready = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        cyc = 1; req_cycles = 0; accepted = 0; accept_cyc = 0; done_cyc = 0;

        while (done_cyc == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.i_dmem_ready  = 1'b0;
            bus.i_dmem_rvalid = 1'b0;
            bus.i_dmem_rdata  = $urandom;
            if (bus.o_valid) begin
                done_cyc = cyc;
            end else if (bus.o_dmem_req) begin
                req_cycles++;
                check_eq({name, "/addr"}, bus.o_dmem_addr, {addr[31:2], 2'b00});
                check_eq({name, "/we"}, 32'(bus.o_dmem_we), 32'(wr));
                if (wr) begin
                    check_eq({name, "/mask"}, 32'(bus.o_dmem_mask), 32'(ref_mask(f3, addr)));
                    check_eq({name, "/wdata"}, bus.o_dmem_wdata, ref_wdata(f3, rs2));
                end
                if (req_cycles > d) begin
                    bus.i_dmem_ready = 1'b1;
                    accepted++;
                    accept_cyc = cyc;
                    if (spurious) begin
                        bus.i_dmem_rvalid = 1'b1;
                        bus.i_dmem_rdata  = ~rdata;
                    end
                end
            end else if (accepted > 0 && cyc == accept_cyc + r) begin
                bus.i_dmem_rvalid = 1'b1;
                bus.i_dmem_rdata  = rdata;
            end
        end

        check_eq({name, "/latency"}, 32'(done_cyc), 32'(exp_lat));
        check_eq({name, "/accepts"}, 32'(accepted), legal_mem ? 32'd1 : 32'd0);
        check_eq({name, "/fault"}, 32'(bus.o_fault), 32'(exp_f));
        if (has_result) check_eq({name, "/result"}, bus.o_result, exp_res);

        // i_valid stays high through DONE: it must not start a new transaction.
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        check_eq({name, "/pulse"}, 32'(bus.o_valid), 32'd0);
        check_eq({name, "/idle"}, 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        check_eq({name, "/idle2"}, 32'(bus.o_busy), 32'd0);
        check_eq({name, "/fhold"}, 32'(bus.o_fault), 32'(exp_f));
        if (has_result) check_eq({name, "/rhold"}, bus.o_result, exp_res);

        if (done_cyc == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic check_reset_state(input string name);
        check_eq({name, "/valid"}, 32'(bus.o_valid), 32'd0);
        check_eq({name, "/busy"}, 32'(bus.o_busy), 32'd0);
        check_eq({name, "/result"}, bus.o_result, 32'd0);
        check_eq({name, "/fault"}, 32'(bus.o_fault), 32'd0);
        check_eq({name, "/req"}, 32'(bus.o_dmem_req), 32'd0);
        check_eq({name, "/we"}, 32'(bus.o_dmem_we), 32'd0);
        check_eq({name, "/mask"}, 32'(bus.o_dmem_mask), 32'd0);
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        bit rd, wr;
        int kind, sz;
        logic [2:0] f3;
        logic [31:0] addr;
        legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        bus.i_valid = 1'b0; bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
        bus.i_funct3 = 3'b000; bus.i_alu_result = 32'h0; bus.i_rs2_data = 32'h0;
        bus.i_dmem_ready = 1'b0; bus.i_dmem_rvalid = 1'b0; bus.i_dmem_rdata = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, 0, "lb_103");
        run_txn(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0, 1, 0, "sh_202");
        run_txn(1, 0, 3'b010, 32'h005, 32'h0, 32'h1111_2222, 0, 1, 0, "lw_misal");
        run_txn(1, 0, 3'b101, 32'h002, 32'h0, 32'hBEEF_0000, 3, 1, 0, "lhu_stall");
        run_txn(1, 1, 3'b010, 32'h100, 32'h5, 32'h0, 0, 1, 0, "rd_wr");
        run_txn(0, 1, 3'b011, 32'h100, 32'h5, 32'h0, 0, 1, 0, "bad_f3");
        run_txn(1, 0, 3'b000, 32'h041, 32'h0, 32'h0000_7F00, 0, 2, 1, "lb_spur");
        run_txn(0, 1, 3'b000, 32'h043, 32'h0000_005A, 32'h0, 1, 1, 0, "sb_043");
        run_txn(0, 0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0, 1, 0, "alu");

        // Reset while a load sits in WAIT; the late rvalid must be discarded.
        bus.i_valid = 1'b1; bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b0;
        bus.i_funct3 = 3'b010; bus.i_alu_result = 32'h40;
        @(negedge clk);
        check_eq("rst_wait/req", 32'(bus.o_dmem_req), 32'd1);
        bus.i_valid = 1'b0;
        bus.i_dmem_ready = 1'b1;
        @(negedge clk);
        bus.i_dmem_ready = 1'b0;
        check_eq("rst_wait/busy", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_dmem_rvalid = 1'b1;
        bus.i_dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.i_dmem_rvalid = 1'b0;
        check_reset_state("rst_wait");
        @(negedge clk);
        check_eq("rst_wait/valid2", 32'(bus.o_valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 3));
            rd = (kind == 1) || (kind == 3 && $urandom_range(0, 3) == 0);
            wr = (kind == 2) || (kind == 3 && !rd) || (kind == 3 && $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            sz = size_bytes(f3);
            if ($urandom_range(0, 1) == 1) addr[1:0] = (sz == 4) ? 2'b00 : (sz == 2 ? {addr[1], 1'b0} : addr[1:0]);
            run_txn(rd, wr, f3, addr, $urandom, $urandom, int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
